// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 decrypt core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_dec_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } aes_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0 in the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, entry 0 in the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Round constant for key-schedule step i; zero outside 1..10 so idle lookups are harmless.
    function automatic logic [7:0] rcon_of(input logic [3:0] i);
        logic [7:0] v;
        v = 8'h00;
        if (i >= 4'd1 && i <= 4'd10) v = RCON[i];
        return v;
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// Register-side bus between the Avalon AES register block and the decrypt core.
// Latency: n/a (wires only).
// Backpressure: none; START/DONE are level handshakes.
interface aes_decrypt_core_if;
    logic         AES_START;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_ENC;
    logic [127:0] AES_MSG_DEC;
    logic         AES_DONE;

    // Register block side.
    modport master (
        output AES_START, AES_KEY, AES_MSG_ENC,
        input  AES_MSG_DEC, AES_DONE
    );

    // Decrypt core side.
    modport slave (
        input  AES_START, AES_KEY, AES_MSG_ENC,
        output AES_MSG_DEC, AES_DONE
    );
endinterface

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: next round key from previous key and Rcon.
// Latency: combinational.
// Backpressure: none.
module aes_key_expand_step
    import aes_dec_pkg::*;
(
    input  logic [127:0] i_prev_key,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_next_key
);
    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = i_prev_key;

    // RotWord moves byte 0 of the last word to the end, then SubWord and Rcon on the first byte.
    assign w_temp = {SBOX[w_w3[23:16]] ^ i_rcon, SBOX[w_w3[15:8]],
                     SBOX[w_w3[7:0]],            SBOX[w_w3[31:24]]};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_next_key = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decrypt: expand key, then one inverse round per clock. Optional AES_DEC_KEY_CACHE_EN skips expansion on a repeated key.
// Latency: 22 cycles start-to-done (12 on a cached-key hit when AES_DEC_KEY_CACHE_EN is defined).
// Backpressure: none; START is a level, DONE holds until START is dropped.
module aes_decrypt_core
    import aes_dec_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    aes_decrypt_core_if.slave bus
);
    aes_state_e   r_state;
    aes_state_e   w_state_nxt;
    logic [3:0]   r_cnt;
    logic [127:0] r_rk [0:10];
    logic [127:0] r_state_dat;
    logic [127:0] r_msg_dec;
    logic         r_done;

    logic [127:0] w_prev_key;
    logic [127:0] w_next_key;
    logic [7:0]   w_rcon;
    logic [127:0] w_inv_sr_sb;
    logic [127:0] w_round_out;
    logic [127:0] w_final_out;
    logic         w_key_hit;

    // Row r is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = INV_SBOX[s[127-8*n -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    // Single key-schedule step shared by all KEYEXP cycles; r_cnt selects the key being built.
    assign w_prev_key = r_rk[r_cnt - 4'd1];
    assign w_rcon     = rcon_of(r_cnt);

    aes_key_expand_step u_key_step (
        .i_prev_key (w_prev_key),
        .i_rcon     (w_rcon),
        .o_next_key (w_next_key)
    );

    // Inverse round datapath; the final round reuses the shift/sub stage without InvMixColumns.
    assign w_inv_sr_sb = inv_sub_bytes(inv_shift_rows(r_state_dat));
    assign w_round_out = inv_mix_columns(w_inv_sr_sb ^ r_rk[r_cnt]);
    assign w_final_out = w_inv_sr_sb ^ r_rk[0];

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] r_cache_key;
    logic         r_cache_vld;

    assign w_key_hit = r_cache_vld && (bus.AES_KEY == r_cache_key);

    // Cache becomes valid only once a full expansion has landed in the round-key store.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cache_key <= '0;
            r_cache_vld <= 1'b0;
        end else if (r_state == ST_IDLE && bus.AES_START && !w_key_hit) begin
            r_cache_vld <= 1'b0;
        end else if (r_state == ST_KEYEXP && r_cnt == 4'(NUM_ROUNDS)) begin
            r_cache_key <= r_rk[0];
            r_cache_vld <= 1'b1;
        end
    end
`else
    assign w_key_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.AES_START) w_state_nxt = w_key_hit ? ST_INIT : ST_KEYEXP;
            ST_KEYEXP: if (r_cnt == 4'(NUM_ROUNDS)) w_state_nxt = ST_INIT;
            ST_INIT:   w_state_nxt = ST_ROUND;
            ST_ROUND:  if (r_cnt == 4'd1) w_state_nxt = ST_FINAL;
            ST_FINAL:  w_state_nxt = ST_DONE;
            ST_DONE:   if (!bus.AES_START) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture, key expansion, rounds and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt       <= '0;
            r_state_dat <= '0;
            r_msg_dec   <= '0;
            r_done      <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.AES_START) begin
                        r_rk[0]     <= bus.AES_KEY;
                        r_state_dat <= bus.AES_MSG_ENC;
                        r_cnt       <= 4'd1;
                    end
                end
                ST_KEYEXP: begin
                    r_rk[r_cnt] <= w_next_key;
                    r_cnt       <= r_cnt + 4'd1;
                end
                ST_INIT: begin
                    r_state_dat <= r_state_dat ^ r_rk[NUM_ROUNDS];
                    r_cnt       <= 4'(NUM_ROUNDS - 1);
                end
                ST_ROUND: begin
                    r_state_dat <= w_round_out;
                    r_cnt       <= r_cnt - 4'd1;
                end
                ST_FINAL: begin
                    r_msg_dec <= w_final_out;
                    r_done    <= 1'b1;
                end
                ST_DONE: begin
                    if (!bus.AES_START) r_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.AES_MSG_DEC = r_msg_dec;
    assign bus.AES_DONE    = r_done;
endmodule
